od_sonar_ctrl: RTL and testbench
================================

OD_SONAR_CTRL -- requirements
Module: od_sonar_ctrl

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 500, meaning trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-002 SHALL have parameter PERIOD_CYCLES, default 3_000_000, meaning cycles from one trigger rise to the next (60 ms).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_250_000, meaning the maximum cycles waited for echo rise and the maximum cycles measured for echo high width.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port en, input, 1, enabling periodic ranging.
REQ-007 SHALL have port echo_pulse, input, 1, raw asynchronous sensor echo.
REQ-008 SHALL have port trig_pulse, output, 1, sensor trigger.
REQ-009 SHALL have port time_taken, output, 23, last valid round-trip echo width in clk cycles.
REQ-010 SHALL have port time_valid, output, 1, one-cycle strobe marking a new time_taken.
REQ-011 SHALL have port time_out, output, 1, level that is high while the most recent measurement failed.

Function
REQ-012 SHALL synchronise echo_pulse through two flops before any use, and detect edges on the synchronised signal with one further flop.
REQ-013 SHALL implement the states IDLE, TRIG, WAIT_RISE, MEASURE and HOLDOFF.
REQ-014 IDLE: SHALL move to TRIG when en=1 and leave all counters at zero.
REQ-015 TRIG: SHALL drive trig_pulse=1 for exactly TRIG_CYCLES cycles, then move to WAIT_RISE; trig_pulse SHALL be 0 in every other state.
REQ-016 WAIT_RISE: SHALL move to MEASURE only on a synchronised rising edge; an echo already high on entry SHALL NOT count as a rise.
REQ-017 WAIT_RISE: if no rise occurs within TIMEOUT_CYCLES, SHALL set time_out=1, leave time_taken unchanged and move to HOLDOFF.
REQ-018 MEASURE: SHALL count cycles while the synchronised echo is high; the count SHALL be 1 in the first cycle echo is seen high.
REQ-019 MEASURE: on the falling edge SHALL load time_taken with the count, pulse time_valid for 1 cycle, clear time_out and move to HOLDOFF.
REQ-020 MEASURE: if the count reaches TIMEOUT_CYCLES with echo still high, SHALL set time_out=1, leave time_taken unchanged, give no time_valid and move to HOLDOFF.
REQ-021 If a falling edge and the count reaching TIMEOUT_CYCLES occur in the same cycle, the falling edge SHALL take priority and the measurement SHALL be valid.
REQ-022 HOLDOFF: SHALL wait until PERIOD_CYCLES have elapsed since the trigger rose, then go to TRIG if en=1, else to IDLE.
REQ-023 Deasserting en mid-cycle SHALL NOT abort the cycle; the current measurement SHALL complete and the FSM SHALL then return to IDLE.
REQ-024 All counters SHALL be 23-bit unsigned and saturate without wrap; parameter values SHALL satisfy TIMEOUT_CYCLES < 2^23 and TRIG_CYCLES + 2*TIMEOUT_CYCLES < PERIOD_CYCLES.
REQ-025 The latency from the synchronised falling edge to time_valid=1 SHALL be 1 cycle.

Reset
REQ-026 While rst=1 at a clk edge: state=IDLE, trig_pulse=0, time_taken=0, time_valid=0, time_out=0, and all counters and synchroniser flops cleared.
REQ-027 rst asserted mid-measurement SHALL discard that measurement without emitting time_valid.

Structure
REQ-028 The state enum type and the default cycle constants SHALL live in the shared package od_pkg.
REQ-029 The two-flop synchroniser SHALL be the sub-module od_sync2; all other logic SHALL live in od_sonar_ctrl.

Verification (TRIG_CYCLES=4, PERIOD_CYCLES=200, TIMEOUT_CYCLES=50)
REQ-030 Scenario: en=1 and echo high for 20 cycles, starting 10 cycles after trigger fall -> trig_pulse high for 4 cycles, time_valid single pulse, time_taken=20, time_out=0.
REQ-031 Scenario: en=1 and echo never rises -> time_out=1 at trigger-fall+50 cycles, no time_valid, next trigger exactly 200 cycles after the previous one.
REQ-032 Scenario: echo held high for 60 cycles -> time_out=1, time_taken keeps the previous value 20, no time_valid; a following 30-cycle echo -> time_taken=30, time_out=0.
REQ-033 Scenario: echo already high before WAIT_RISE, falling then re-rising for 15 cycles -> time_taken=15.
REQ-034 Scenario: echo falls in the same cycle the count hits 50 -> time_valid=1, time_taken=50, time_out=0.
REQ-035 Scenario: rst pulsed for 1 cycle during MEASURE -> all outputs 0 the next cycle, no time_valid, new trigger starts when en=1.

Source files
------------

// File: rtl/od_pkg.sv
// Shared types and default timing for the ultrasonic ranging controller.
package od_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } od_state_e;

  localparam int unsigned CNT_W              = 23;
  localparam int unsigned TRIG_CYCLES_DEF    = 500;
  localparam int unsigned PERIOD_CYCLES_DEF  = 3_000_000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1_250_000;

  typedef logic [CNT_W-1:0] od_cnt_t;

  function automatic od_cnt_t sat_inc(input od_cnt_t v);
    return (v == '1) ? v : v + od_cnt_t'(1);
  endfunction

endpackage

// File: rtl/od_sync2.sv
// Two-flop synchroniser for the asynchronous echo input.
module od_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/od_sonar_ctrl.sv
// Periodic sonar ranging: trigger pulse, wait for echo, measure echo width.
module od_sonar_ctrl
  import od_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int unsigned PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        echo_pulse,
  output logic        trig_pulse,
  output logic [22:0] time_taken,
  output logic        time_valid,
  output logic        time_out
);

  localparam od_cnt_t TRIG_LAST   = od_cnt_t'(TRIG_CYCLES - 1);
  localparam od_cnt_t PERIOD_LAST = od_cnt_t'(PERIOD_CYCLES - 1);
  localparam od_cnt_t WAIT_LAST   = od_cnt_t'(TIMEOUT_CYCLES - 1);
  localparam od_cnt_t MEAS_MAX    = od_cnt_t'(TIMEOUT_CYCLES);

  od_state_e state_q, state_d;
  od_cnt_t   period_q, period_d;
  od_cnt_t   cnt_q, cnt_d;
  od_cnt_t   time_taken_q, time_taken_d;
  logic      time_valid_q, time_valid_d;
  logic      time_out_q, time_out_d;
  logic      echo_prev_q, echo_prev_d;
  logic      echo_s;
  logic      echo_rise, echo_fall;

  od_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (echo_pulse),
    .q   (echo_s)
  );

  assign echo_rise = echo_s & ~echo_prev_q;
  assign echo_fall = ~echo_s & echo_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      period_q     <= '0;
      cnt_q        <= '0;
      time_taken_q <= '0;
      time_valid_q <= 1'b0;
      time_out_q   <= 1'b0;
      echo_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      time_taken_q <= time_taken_d;
      time_valid_q <= time_valid_d;
      time_out_q   <= time_out_d;
      echo_prev_q  <= echo_prev_d;
    end
  end

  // en is only sampled in IDLE and at the end of HOLDOFF, so a started cycle always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (en) state_d = TRIG;
      TRIG:      if (period_q >= TRIG_LAST) state_d = WAIT_RISE;
      WAIT_RISE: begin
        if (echo_rise)               state_d = MEASURE;
        else if (cnt_q >= WAIT_LAST) state_d = HOLDOFF;
      end
      MEASURE:   if (echo_fall || (cnt_q >= MEAS_MAX)) state_d = HOLDOFF;
      HOLDOFF:   if (period_q >= PERIOD_LAST) state_d = en ? TRIG : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // period counts from the trigger rise; cnt serves both the rise timeout and the echo width.
  always_comb begin
    period_d     = sat_inc(period_q);
    cnt_d        = sat_inc(cnt_q);
    time_taken_d = time_taken_q;
    time_valid_d = 1'b0;
    time_out_d   = time_out_q;
    echo_prev_d  = echo_s;
    case (state_q)
      IDLE: begin
        period_d = '0;
        cnt_d    = '0;
      end
      TRIG:    cnt_d = '0;
      WAIT_RISE: begin
        if (echo_rise)               cnt_d = od_cnt_t'(1);
        else if (cnt_q >= WAIT_LAST) time_out_d = 1'b1;
      end
      MEASURE: begin
        if (echo_fall) begin
          time_taken_d = cnt_q;
          time_valid_d = 1'b1;
          time_out_d   = 1'b0;
        end else if (cnt_q >= MEAS_MAX) begin
          time_out_d = 1'b1;
        end
      end
      HOLDOFF: cnt_d = '0;
      default: cnt_d = '0;
    endcase
    if ((state_d == TRIG) && (state_q != TRIG)) period_d = '0;
  end

  always_comb begin
    trig_pulse = (state_q == TRIG);
    time_taken = time_taken_q;
    time_valid = time_valid_q;
    time_out   = time_out_q;
  end

endmodule

// File: tb/tb_od_sonar_ctrl.sv
// Bench for od_sonar_ctrl: edge-indexed behavioural model plus directed scenarios.
module tb_od_sonar_ctrl;

  localparam int TRIG   = 4;
  localparam int PERIOD = 200;
  localparam int TOUT   = 50;
  localparam int NMAX   = 4096;
  localparam int S_ECHO = 0;
  localparam int S_EN   = 1;
  localparam int S_RST  = 2;

  logic        clk = 1'b0;
  logic        rst, en, echo_pulse;
  logic        trig_pulse, time_valid, time_out;
  logic [22:0] time_taken;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int cur_edge = -1;

  od_sonar_ctrl #(
    .TRIG_CYCLES    (TRIG),
    .PERIOD_CYCLES  (PERIOD),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .echo_pulse (echo_pulse),
    .trig_pulse (trig_pulse),
    .time_taken (time_taken),
    .time_valid (time_valid),
    .time_out   (time_out)
  );

  always #5 clk = ~clk;

  // Model state: inputs recorded per active edge, outcome derived from offsets to the trigger edge.
  logic        e_a    [0:NMAX-1];
  logic        en_a   [0:NMAX-1];
  logic        rst_a  [0:NMAX-1];
  logic        seen_a [0:NMAX-1];
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  int          m_t    = 0;
  int          m_rise = -1;
  logic        m_trig, m_valid;
  logic        m_out   = 1'b0;
  logic [22:0] m_taken = '0;

  initial begin
    int k, o;
    forever begin
      @(posedge clk);
      k = cur_edge + 1;
      if (k >= NMAX) begin
        $display("FAIL model_capacity: edge %0d exceeds %0d", k, NMAX);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
      end
      e_a[k]   = echo_pulse;
      en_a[k]  = en;
      rst_a[k] = rst;
      seen_a[k] = (k == 0 || rst_a[k] || rst_a[k-1]) ? 1'b0 : e_a[k-1];
      #1;
      cur_edge = k;
      m_valid = 1'b0;
      if (rst_a[k]) begin
        m_run   = 1'b0;
        m_taken = '0;
        m_out   = 1'b0;
      end else if (!m_run) begin
        if (en_a[k]) begin
          m_run = 1'b1; m_t = k; m_rise = -1; m_done = 1'b0;
        end
      end else begin
        o = k - m_t;
        if (o >= PERIOD) begin
          if (en_a[k]) begin
            m_t = k; m_rise = -1; m_done = 1'b0;
          end else begin
            m_run = 1'b0;
          end
        end else if (!m_done) begin
          if (m_rise < 0) begin
            if (o >= TRIG && o < TRIG + TOUT && seen_a[k] && !seen_a[k-1]) m_rise = k;
            else if (o == TRIG + TOUT) begin
              m_out = 1'b1; m_done = 1'b1;
            end
          end else if (!seen_a[k-1]) begin
            m_valid = 1'b1;
            m_taken = 23'(k - 1 - m_rise);
            m_out   = 1'b0;
            m_done  = 1'b1;
          end else if (k - 1 - m_rise == TOUT) begin
            m_out = 1'b1; m_done = 1'b1;
          end
        end
      end
      m_trig = m_run && ((k - m_t) < TRIG);

      if (time_valid === 1'b1) n_valid++;
      n_tests++;
      if (trig_pulse !== m_trig || time_valid !== m_valid ||
          time_out !== m_out || time_taken !== m_taken) begin
        n_fail++;
        $display("FAIL cycle_%0d trig/valid/out/taken: got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 k, trig_pulse, time_valid, time_out, time_taken,
                 m_trig, m_valid, m_out, m_taken);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cur_edge, act, exp);
    end
  endtask

  task automatic at_edge(input int e);
    while (cur_edge < e) @(negedge clk);
  endtask

  // Sets a stimulus signal so that it is sampled at active edge e.
  task automatic drive(input int e, input int which, input logic v);
    while (cur_edge < e - 1) @(negedge clk);
    if (cur_edge != e - 1) begin
      n_fail++;
      $display("FAIL schedule: edge %0d already passed, now %0d", e, cur_edge);
    end
    case (which)
      S_ECHO:  echo_pulse = v;
      S_EN:    en = v;
      default: rst = v;
    endcase
  endtask

  // Synchronised echo high for n edges starting at edge a.
  task automatic echo_window(input int a, input int n);
    drive(a - 1, S_ECHO, 1'b1);
    drive(a - 1 + n, S_ECHO, 1'b0);
  endtask

  initial begin
    int t;
    rst = 1'b1; en = 1'b0; echo_pulse = 1'b0;

    at_edge(2);
    chk("reset_trig", int'(trig_pulse), 0);
    chk("reset_taken", int'(time_taken), 0);
    chk("reset_valid", int'(time_valid), 0);
    chk("reset_out", int'(time_out), 0);
    drive(3, S_RST, 1'b0);
    at_edge(4);
    chk("idle_no_trig", int'(trig_pulse), 0);
    drive(5, S_EN, 1'b1);

    t = 5;
    at_edge(t);     chk("s1_trig_first", int'(trig_pulse), 1);
    at_edge(t + 3); chk("s1_trig_last", int'(trig_pulse), 1);
    at_edge(t + 4); chk("s1_trig_fall", int'(trig_pulse), 0);
    echo_window(t + 14, 20);
    at_edge(t + 35);
    chk("s1_valid", int'(time_valid), 1);
    chk("s1_taken", int'(time_taken), 20);
    chk("s1_out", int'(time_out), 0);
    at_edge(t + 36); chk("s1_valid_single", int'(time_valid), 0);

    t = 205;
    at_edge(t + 53);  chk("s2_out_before", int'(time_out), 0);
    at_edge(t + 54);  chk("s2_out", int'(time_out), 1);
    chk("s2_taken_kept", int'(time_taken), 20);
    at_edge(t + 199); chk("s2_no_early_trig", int'(trig_pulse), 0);
    at_edge(t + 200); chk("s2_period_trig", int'(trig_pulse), 1);

    t = 405;
    echo_window(t + 10, 60);
    at_edge(t + 75);
    chk("s3_out", int'(time_out), 1);
    chk("s3_taken_kept", int'(time_taken), 20);
    at_edge(t + 150); chk("s3_valid_count", n_valid, 1);

    t = 605;
    echo_window(t + 10, 30);
    at_edge(t + 41);
    chk("s4_valid", int'(time_valid), 1);
    chk("s4_taken", int'(time_taken), 30);
    chk("s4_out", int'(time_out), 0);

    t = 805;
    echo_window(t + 2, 6);
    echo_window(t + 10, 15);
    at_edge(t + 26);
    chk("s5_valid", int'(time_valid), 1);
    chk("s5_taken", int'(time_taken), 15);

    t = 1005;
    echo_window(t + 10, 50);
    at_edge(t + 61);
    chk("s6_valid", int'(time_valid), 1);
    chk("s6_taken", int'(time_taken), 50);
    chk("s6_out", int'(time_out), 0);

    t = 1205;
    echo_window(t + 10, 51);
    at_edge(t + 60); chk("s7_out_before", int'(time_out), 0);
    at_edge(t + 61);
    chk("s7_out", int'(time_out), 1);
    chk("s7_taken_kept", int'(time_taken), 50);

    t = 1405;
    drive(t + 9, S_ECHO, 1'b1);
    drive(t + 20, S_RST, 1'b1);
    at_edge(t + 20);
    chk("s8_rst_trig", int'(trig_pulse), 0);
    chk("s8_rst_taken", int'(time_taken), 0);
    chk("s8_rst_valid", int'(time_valid), 0);
    chk("s8_rst_out", int'(time_out), 0);
    drive(t + 21, S_RST, 1'b0);
    at_edge(t + 21); chk("s8_retrigger", int'(trig_pulse), 1);
    t = t + 21;
    drive(t + 18, S_ECHO, 1'b0);
    drive(t + 30, S_EN, 1'b0);
    at_edge(t + 54); chk("s8_high_on_entry_timeout", int'(time_out), 1);
    at_edge(t + 60); chk("s8_valid_count", n_valid, 4);
    at_edge(t + 200); chk("s9_idle_no_trig", int'(trig_pulse), 0);
    at_edge(t + 260);
    chk("s9_still_idle", int'(trig_pulse), 0);
    chk("s9_taken", int'(time_taken), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete by time %0t", $time);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
